// File: rtl/minv_seq.sv
// Sequencer for the 256-bit modular-inverse unit: load p/a, start, wait, unload.
// Optional WAIT-state watchdog enabled by defining MINV_SEQ_TIMEOUT_EN.
module minv_seq #(
  parameter int DW          = 16,
  parameter int NWORDS      = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] mv_datain,
  output logic          mv_loadp,
  output logic          mv_loada,
  output logic          mv_en,
  output logic          mv_outx1,
  output logic          mv_outx2,
  output logic          mv_outt,
  input  logic          mv_rdy,
  input  logic [1:0]    mv_flag,
  input  logic [DW-1:0] mv_x1out,
  input  logic [DW-1:0] mv_x2out,
  input  logic [DW-1:0] mv_tout
);

  localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADP,
    S_LOADA,
    S_START,
    S_WAIT,
    S_UNLOAD
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    flag_q, flag_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          in_hs, out_hs, last_w, tmo;

  assign busy      = (state_q != S_IDLE);
  assign in_ready  = (state_q == S_LOADP) || (state_q == S_LOADA);
  assign out_valid = (state_q == S_UNLOAD);
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  assign last_w    = (cnt_q == LAST);
  assign out_last  = out_valid & last_w;
  assign done      = done_q;
  assign err       = err_q;

  assign mv_datain = in_data;
  assign mv_loadp  = in_hs & (state_q == S_LOADP);
  assign mv_loada  = in_hs & (state_q == S_LOADA);
  assign mv_en     = (state_q == S_START);
  assign mv_outx1  = out_hs & (flag_q == 2'b00);
  assign mv_outx2  = out_hs & (flag_q == 2'b01);
  assign mv_outt   = out_hs & (flag_q == 2'b11);

`ifdef MINV_SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] tcnt_q;

  // Counts WAIT cycles; zero on every WAIT entry since it clears elsewhere
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q <= '0;
    end else if (state_q == S_WAIT) begin
      tcnt_q <= tcnt_q + TW'(1);
    end else begin
      tcnt_q <= '0;
    end
  end

  assign tmo = (tcnt_q == TW'(TIMEOUT_CYC - 1));
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign tmo = 1'b0;
`endif

  always_comb begin
    out_data = '0;
    if (state_q == S_UNLOAD) begin
      unique case (flag_q)
        2'b00:   out_data = mv_x1out;
        2'b01:   out_data = mv_x2out;
        2'b11:   out_data = mv_tout;
        default: out_data = '0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOADP;
          cnt_d   = '0;
        end
      end
      S_LOADP, S_LOADA: begin
        if (in_hs) begin
          cnt_d = last_w ? '0 : cnt_q + CW'(1);
          if (last_w) begin
            state_d = (state_q == S_LOADP) ? S_LOADA : S_START;
          end
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        // Ready beats the watchdog when both land in the same cycle
        if (mv_rdy) begin
          flag_d = mv_flag;
          if (mv_flag == 2'b10) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = S_UNLOAD;
            cnt_d   = '0;
          end
        end else if (tmo) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      S_UNLOAD: begin
        if (out_hs) begin
          cnt_d = last_w ? '0 : cnt_q + CW'(1);
          if (last_w) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      flag_q  <= 2'b00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule
